// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - MIPS data-memory controller with byte-lane stores, extended loads and wait states
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   dm_req        access request, taken in IDLE or DONE, ignored in WAIT
//   dm_we         1 = store, 0 = load
//   dm_size       00 byte, 01 half, 10 word, 11 illegal
//   dm_unsigned   zero-extend (1) or sign-extend (0) byte/half loads
//   dm_address    byte address; word index wraps modulo ADDRESSES
//   dm_d          right-aligned store data
//   dm_q          right-aligned, extended load result (0 after stores/errors)
//   dm_ready      one-cycle completion pulse
//   dm_busy       high while waiting out wait states
//   dm_error      high with dm_ready when the access was rejected
module dm_ctrl #(
  parameter int DATA_SIZE   = 32,
  parameter int SELEC_SIZE  = 16,
  parameter int ADDRESSES   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [1:0]            dm_size,
  input  logic                  dm_unsigned,
  input  logic [SELEC_SIZE-1:0] dm_address,
  input  logic [DATA_SIZE-1:0]  dm_d,
  output logic [DATA_SIZE-1:0]  dm_q,
  output logic                  dm_ready,
  output logic                  dm_busy,
  output logic                  dm_error
);

  localparam int IDX_W = $clog2(ADDRESSES);
  // Counter preload: WAIT lasts WAIT_STATES cycles, counting down to zero.
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]              size_q, size_d;
  logic [SELEC_SIZE-1:0]   addr_q, addr_d;
  logic [DATA_SIZE-1:0]    d_q, d_d, q_q, q_d;

  logic [DATA_SIZE-1:0]    mem [ADDRESSES];

  // The operation being executed: latched fields while waiting, live inputs
  // when the access completes on the accepting edge (no wait states).
  logic                    op_we, op_uns, op_illegal, accept, mem_we;
  logic [1:0]              op_size, lane;
  logic [SELEC_SIZE-1:0]   op_addr;
  logic [DATA_SIZE-1:0]    op_d, rd_word, wr_word, wdata, load_val;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              be;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic                    unused_addr_bits;

  assign accept  = dm_req && (state_q != S_WAIT);
  assign op_we   = (state_q == S_WAIT) ? we_q   : dm_we;
  assign op_uns  = (state_q == S_WAIT) ? uns_q  : dm_unsigned;
  assign op_size = (state_q == S_WAIT) ? size_q : dm_size;
  assign op_addr = (state_q == S_WAIT) ? addr_q : dm_address;
  assign op_d    = (state_q == S_WAIT) ? d_q    : dm_d;

  assign op_illegal = (op_size == 2'b11) ||
                      (op_size == 2'b01 && op_addr[0]) ||
                      (op_size == 2'b10 && op_addr[1:0] != 2'b00);

  assign lane    = op_addr[1:0];
  assign idx     = op_addr[IDX_W+1:2];
  assign rd_word = mem[idx];
  assign byte_v  = rd_word[{lane, 3'b000} +: 8];
  assign half_v  = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign unused_addr_bits = ^op_addr[SELEC_SIZE-1:IDX_W+2];

  always_comb begin
    wdata = op_d;
    be    = 4'b1111;
    case (op_size)
      2'b00: begin
        wdata = {4{op_d[7:0]}};
        be    = 4'b0001 << lane;
      end
      2'b01: begin
        wdata = {2{op_d[15:0]}};
        be    = op_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    wr_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_comb begin
    case (op_size)
      2'b00:   load_val = {{(DATA_SIZE-8){byte_v[7] & ~op_uns}}, byte_v};
      2'b01:   load_val = {{(DATA_SIZE-16){half_v[15] & ~op_uns}}, half_v};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    d_d     = d_q;
    err_d   = err_q;
    q_d     = q_q;
    mem_we  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          mem_we  = op_we;
          q_d     = op_we ? '0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          we_d   = dm_we;
          uns_d  = dm_unsigned;
          size_d = dm_size;
          addr_d = dm_address;
          d_d    = dm_d;
          if (op_illegal) begin
            // Rejected accesses skip wait states and never touch the array.
            state_d = S_DONE;
            err_d   = 1'b1;
            q_d     = '0;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DONE;
            err_d   = 1'b0;
            mem_we  = op_we;
            q_d     = op_we ? '0 : load_val;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      err_q   <= err_d;
      q_q     <= q_d;
    end
  end

  // Array is not reset; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx] <= wr_word;
  end

  assign dm_q     = q_q;
  assign dm_ready = (state_q == S_DONE);
  assign dm_busy  = (state_q == S_WAIT);
  assign dm_error = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - self-checking bench for dm_ctrl (instances with 0 and 2 wait states)
module tb_dm_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        req  [2];
  logic        we   [2];
  logic        uns  [2];
  logic [1:0]  size [2];
  logic [15:0] addr [2];
  logic [31:0] d    [2];
  logic [31:0] q    [2];
  logic        rdy  [2];
  logic        busy [2];
  logic        err  [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dm_ctrl #(.DATA_SIZE(32), .SELEC_SIZE(16), .ADDRESSES(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .dm_req(req[0]), .dm_we(we[0]), .dm_size(size[0]),
    .dm_unsigned(uns[0]), .dm_address(addr[0]), .dm_d(d[0]), .dm_q(q[0]),
    .dm_ready(rdy[0]), .dm_busy(busy[0]), .dm_error(err[0])
  );

  dm_ctrl #(.DATA_SIZE(32), .SELEC_SIZE(16), .ADDRESSES(256), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst[1]), .dm_req(req[1]), .dm_we(we[1]), .dm_size(size[1]),
    .dm_unsigned(uns[1]), .dm_address(addr[1]), .dm_d(d[1]), .dm_q(q[1]),
    .dm_ready(rdy[1]), .dm_busy(busy[1]), .dm_error(err[1])
  );

  typedef struct {
    logic [31:0] q;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] addr;
    logic [31:0] d;
    logic [31:0] exp_q;
    logic        exp_err;
  } vec_t;

  exp_t sb [2][$];
  exp_t mon_e;
  vec_t vt [16];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  // Completion monitor: every dm_ready must match the oldest expected result.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("error_without_ready%0d", w), {31'b0, err[w] & ~rdy[w]}, 32'd0);
      if (rdy[w] === 1'b1) begin
        if (sb[w].size() == 0) begin
          chk($sformatf("unexpected_ready%0d", w), 32'd1, 32'd0);
        end else begin
          mon_e = sb[w].pop_front();
          chk($sformatf("q%0d", w), q[w], mon_e.q);
          chk($sformatf("error%0d", w), {31'b0, err[w]}, {31'b0, mon_e.err});
          chk($sformatf("ready_cycle%0d", w), cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic drive(input int w, input logic we_v, input logic [1:0] sz, input logic u,
                       input logic [15:0] a, input logic [31:0] dv);
    req[w]  = 1'b1;
    we[w]   = we_v;
    size[w] = sz;
    uns[w]  = u;
    addr[w] = a;
    d[w]    = dv;
  endtask

  task automatic expect_done(input int w, input logic [31:0] eq, input logic ee, input int lat);
    exp_t e;
    e.q   = eq;
    e.err = ee;
    e.cyc = cyc + lat;
    sb[w].push_back(e);
  endtask

  task automatic drain(input int w);
    for (int k = 0; k < 20; k++) begin
      if (sb[w].size() == 0) break;
      @(posedge clk);
    end
    chk($sformatf("drain_timeout%0d", w), sb[w].size(), 32'd0);
    sb[w].delete();
  endtask

  task automatic send(input int w, input logic we_v, input logic [1:0] sz, input logic u,
                      input logic [15:0] a, input logic [31:0] dv,
                      input logic [31:0] eq, input logic ee);
    @(posedge clk); #1;
    drive(w, we_v, sz, u, a, dv);
    // Illegal accesses bypass the wait states.
    expect_done(w, eq, ee, (w == 1 && !ee) ? 3 : 1);
    @(posedge clk); #1;
    req[w] = 1'b0;
    drain(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      rst[w] = 1'b1; req[w] = 1'b0; we[w] = 1'b0; uns[w] = 1'b0;
      size[w] = 2'b00; addr[w] = '0; d[w] = '0;
    end

    vt[0]  = '{1'b1, 2'b10, 1'b0, 16'h0004, 32'h11223344, 32'h00000000, 1'b0};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 16'h0004, 32'h0,        32'h11223344, 1'b0};
    vt[2]  = '{1'b1, 2'b00, 1'b0, 16'h0005, 32'h000000AB, 32'h00000000, 1'b0};
    vt[3]  = '{1'b0, 2'b10, 1'b0, 16'h0004, 32'h0,        32'h1122AB44, 1'b0};
    vt[4]  = '{1'b0, 2'b00, 1'b0, 16'h0005, 32'h0,        32'hFFFFFFAB, 1'b0};
    vt[5]  = '{1'b0, 2'b00, 1'b1, 16'h0005, 32'h0,        32'h000000AB, 1'b0};
    vt[6]  = '{1'b1, 2'b01, 1'b0, 16'h0006, 32'h00008001, 32'h00000000, 1'b0};
    vt[7]  = '{1'b0, 2'b01, 1'b0, 16'h0006, 32'h0,        32'hFFFF8001, 1'b0};
    vt[8]  = '{1'b0, 2'b01, 1'b1, 16'h0006, 32'h0,        32'h00008001, 1'b0};
    vt[9]  = '{1'b0, 2'b01, 1'b1, 16'h0004, 32'h0,        32'h0000AB44, 1'b0};
    vt[10] = '{1'b1, 2'b10, 1'b0, 16'h0006, 32'hDEADBEEF, 32'h00000000, 1'b1};
    vt[11] = '{1'b1, 2'b11, 1'b0, 16'h0004, 32'hCAFEBABE, 32'h00000000, 1'b1};
    vt[12] = '{1'b0, 2'b10, 1'b0, 16'h0004, 32'h0,        32'h8001AB44, 1'b0};
    vt[13] = '{1'b0, 2'b01, 1'b0, 16'h0005, 32'h0,        32'h00000000, 1'b1};
    vt[14] = '{1'b0, 2'b00, 1'b0, 16'h0007, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[15] = '{1'b0, 2'b10, 1'b0, 16'h0404, 32'h0,        32'h8001AB44, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("reset_q%0d", w), q[w], 32'd0);
      chk($sformatf("reset_ready%0d", w), {31'b0, rdy[w]}, 32'd0);
      chk($sformatf("reset_busy%0d", w), {31'b0, busy[w]}, 32'd0);
      chk($sformatf("reset_error%0d", w), {31'b0, err[w]}, 32'd0);
    end

    for (int i = 0; i < 16; i++)
      send(0, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].d, vt[i].exp_q, vt[i].exp_err);

    // Back-to-back: load accepted in the DONE cycle of a store sees the new data.
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b10, 1'b0, 16'h0010, 32'hCAFEF00D);
    expect_done(0, 32'h0, 1'b0, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    expect_done(0, 32'hCAFEF00D, 1'b0, 1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    drain(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("q_hold", q[0], 32'hCAFEF00D);

    // Wait states: busy for two cycles, request during WAIT ignored.
    send(1, 1'b1, 2'b10, 1'b0, 16'h0000, 32'hA5A5A5A5, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b10, 1'b0, 16'h0000, 32'h0);
    expect_done(1, 32'hA5A5A5A5, 1'b0, 3);
    @(posedge clk); #1;
    chk("busy_t1", {31'b0, busy[1]}, 32'd1);
    drive(1, 1'b1, 2'b10, 1'b0, 16'h0000, 32'h00000000);
    @(posedge clk); #1;
    chk("busy_t2", {31'b0, busy[1]}, 32'd1);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("busy_t3", {31'b0, busy[1]}, 32'd0);
    drain(1);
    repeat (5) @(posedge clk);

    // Reset during WAIT aborts the store.
    @(posedge clk); #1;
    drive(1, 1'b1, 2'b00, 1'b0, 16'h0000, 32'h00000055);
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("busy_before_abort", {31'b0, busy[1]}, 32'd1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("busy_after_abort", {31'b0, busy[1]}, 32'd0);
    chk("q_after_abort", q[1], 32'd0);
    repeat (5) @(posedge clk);
    send(1, 1'b0, 2'b10, 1'b0, 16'h0000, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Address wrap: 0x0400 aliases word 0 with 256 words.
    send(1, 1'b1, 2'b10, 1'b0, 16'h0400, 32'h12345678, 32'h0, 1'b0);
    send(1, 1'b0, 2'b10, 1'b0, 16'h0000, 32'h0, 32'h12345678, 1'b0);
    send(1, 1'b1, 2'b11, 1'b0, 16'h0000, 32'h0, 32'h0, 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
Parametrised data-memory controller for the MIPS datapath. It serves byte-addressed MIPS loads and stores (byte, half and word, with signed or unsigned loads) using a word-wide internal array with per-byte-lane writes. Every access uses a req/ready handshake with a configurable number of wait states, and misaligned or illegal accesses are reported as errors. It sits between the MEM stage and the memory array, and the pipeline stalls on dm_busy.

Parameters:
DATA_SIZE, 32, word width in bits; fixed at 32 (4 byte lanes), other values unsupported
SELEC_SIZE, 16, byte-address width
ADDRESSES, 256, array depth in words (power of two)
WAIT_STATES, 0, extra cycles inserted before each legal access completes (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
dm_req  input  1  access request, sampled when dm_busy=0
dm_we  input  1  1=store, 0=load
dm_size  input  2  00=byte, 01=half, 10=word, 11=illegal
dm_unsigned  input  1  load zero-extends when 1, sign-extends when 0
dm_address  input  SELEC_SIZE  byte address
dm_d  input  DATA_SIZE  store data, right-aligned (byte in [7:0], half in [15:0])
dm_q  output  DATA_SIZE  load result, right-aligned and extended
dm_ready  output  1  one-cycle completion pulse
dm_busy  output  1  1 while in WAIT; requests ignored
dm_error  output  1  qualifies dm_ready: access rejected

Behaviour:
- Reset: state=IDLE, wait counter=0, dm_q=0, dm_ready=0, dm_busy=0, dm_error=0. Array contents are not reset.
- Reset asserted in any state aborts the in-flight access. No array write occurs and no dm_ready is produced.
- States: IDLE, WAIT, DONE.
- Acceptance: dm_req=1 in IDLE or DONE. On acceptance, latch address, size, we, unsigned and d.
- Request in WAIT: ignored, not queued.
- Transition after a legal accept: goes to WAIT when WAIT_STATES>0, otherwise directly to DONE.
- WAIT: lasts exactly WAIT_STATES cycles with dm_busy=1, then goes to DONE.
- Array access: the array write or read happens on the clock edge entering DONE.
- DONE: lasts 1 cycle with dm_ready=1. It then returns to IDLE, or re-accepts a new dm_req in the same cycle, giving back-to-back operation.
- Latency: request accepted in cycle T gives dm_ready in cycle T+1+WAIT_STATES.
- Word index: dm_address[SELEC_SIZE-1:2] modulo ADDRESSES, so higher addresses alias and wrap.
- Lane select: little-endian, lane = address[1:0].
- Legality rules:
  - half requires address[0]=0
  - word requires address[1:0]=00
  - size=11 is always illegal
- Illegal access:
  - no wait states, DONE entered at T+1
  - dm_ready=1, dm_error=1, dm_q=0
  - array untouched for both loads and stores
- Store lane enables:
  - byte writes lane address[1:0] with dm_d[7:0]
  - half writes lanes {addr[1],0} and {addr[1],1} with dm_d[15:0]
  - word writes all lanes
  - lanes not enabled keep their old contents
- Load:
  - extract the selected byte or half, then sign- or zero-extend per dm_unsigned
  - word loads ignore dm_unsigned
- dm_q holds its value until the next completion. A store completion sets dm_q=0.
- dm_error is 0 whenever dm_ready=0.
- Read after write: a load accepted in the DONE cycle of a store sees the stored data.

Test Plan:
1. Word path: WAIT_STATES=0; store word 0x11223344 at 0x0004, then load word 0x0004 -> dm_ready one cycle after each request, dm_q=0x11223344, dm_error=0.
2. Byte lane merge: after test 1, store byte 0xAB at 0x0005. Load word 0x0004 -> 0x1122AB44. Load byte 0x0005 signed -> 0xFFFFFFAB. Load byte 0x0005 unsigned -> 0x000000AB.
3. Half path: store half 0x8001 at 0x0006, then load half 0x0006 signed -> 0xFFFF8001; unsigned -> 0x00008001. Lower lanes of the word at 0x0004 remain 0xAB44.
4. Errors: store word 0xDEADBEEF at 0x0006, then store with size=11 at 0x0004 -> dm_error=1 at T+1 for each, dm_q=0. A subsequent word load at 0x0004 returns the prior value unchanged.
5. Wait states and busy: WAIT_STATES=2; load accepted at cycle T -> dm_busy=1 in T+1..T+2 and dm_ready at T+3. A dm_req at T+1 is ignored and produces no second dm_ready.
6. Reset and wrap: WAIT_STATES=2. Assert rst during WAIT of a store 0x55 to 0x0000 -> no dm_ready and word 0 unchanged. Then, with ADDRESSES=256, store 0x12345678 at 0x0400 and load 0x0000 -> 0x12345678.
